// File: rtl/rv32v_memory_arbitor_pkg.sv
// Shared types and helpers for the scalar/vector memory arbiter and CB age logic.
package rv32v_types_pkg;

  localparam int NUM_CB_ENTRY_DFLT = 16;
  localparam int CB_IDX_W_DFLT     = $clog2(NUM_CB_ENTRY_DFLT);
  localparam int CB_AGE_W          = 8;   // widest CB index the age helper handles
  localparam int MEM_ADDR_W        = 32;
  localparam int MEM_DATA_W        = 32;
  localparam int MEM_BE_W          = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCALAR_XFER = 2'd1,
    VECTOR_XFER = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  ren;
    logic                  wen;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   byte_en;
  } mem_req_t;

  // Distance of a CB entry from the commit pointer, wrapped to idx_w bits.
  function automatic logic [CB_AGE_W-1:0] cb_age(
    input logic [CB_AGE_W-1:0] idx,
    input logic [CB_AGE_W-1:0] tail,
    input int unsigned         idx_w = CB_IDX_W_DFLT
  );
    logic [CB_AGE_W-1:0] mask;
    mask = (CB_AGE_W'(1) << idx_w) - CB_AGE_W'(1);
    return (idx - tail) & mask;
  endfunction

endpackage

// File: rtl/rv32v_memory_arbitor_if.sv
// Generic single-access memory port: requester (master) toward a responder (slave).
interface rv32v_memory_arbitor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  ren;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_W-1:0]       byte_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  modport master (output ren, wen, addr, wdata, byte_en, input rdata, busy);
  modport slave  (input ren, wen, addr, wdata, byte_en, output rdata, busy);
endinterface

// File: rtl/rv32v_cb_age_compare.sv
// Decides whether the scalar CB entry is at least as old as the vector one.
module rv32v_cb_age_compare
  import rv32v_types_pkg::*;
#(
  parameter int CB_IDX_W = CB_IDX_W_DFLT
) (
  input  logic [CB_IDX_W-1:0] tail_i,
  input  logic [CB_IDX_W-1:0] scalar_idx_i,
  input  logic [CB_IDX_W-1:0] vector_idx_i,
  output logic                scalar_older_o
);
  logic [CB_AGE_W-1:0] scalar_age_s;
  logic [CB_AGE_W-1:0] vector_age_s;

  // Ages relative to the commit pointer; a tie counts as scalar-older.
  always_comb begin
    scalar_age_s   = cb_age(CB_AGE_W'(scalar_idx_i), CB_AGE_W'(tail_i), unsigned'(CB_IDX_W));
    vector_age_s   = cb_age(CB_AGE_W'(vector_idx_i), CB_AGE_W'(tail_i), unsigned'(CB_IDX_W));
    scalar_older_o = (scalar_age_s <= vector_age_s);
  end
endmodule

// File: rtl/rv32v_memory_arbitor_chk.sv
// Simulation-only checks on requester behaviour seen by the arbiter.
module rv32v_memory_arbitor_chk (
  input logic clk_i,
  input logic rst_i,
  input logic scalar_ren_i,
  input logic scalar_wen_i,
  input logic vector_ren_i,
  input logic vector_wen_i
);
  // Flag a side that asserts read and write together; the arbiter lets the write win.
  always @(posedge clk_i) begin
    if (!rst_i && scalar_ren_i && scalar_wen_i) begin
      $warning("scalar side drives ren and wen together; write takes priority");
    end
    if (!rst_i && vector_ren_i && vector_wen_i) begin
      $warning("vector side drives ren and wen together; write takes priority");
    end
  end
endmodule

// File: rtl/rv32v_memory_arbitor.sv
// Single-port memory arbiter: scalar vs vector memory stage, oldest CB entry wins.
module rv32v_memory_arbitor
  import rv32v_types_pkg::*;
#(
  parameter  int NUM_CB_ENTRY = 16,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int DATA_WIDTH   = 32,
  localparam int CB_IDX_W     = $clog2(NUM_CB_ENTRY),
  localparam int BE_W         = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CB_IDX_W-1:0]   cb_tail_index,
  input  logic [CB_IDX_W-1:0]   scalar_cb_index,
  input  logic [CB_IDX_W-1:0]   vector_cb_index,
  rv32v_memory_arbitor_if.slave  scalar_if,
  rv32v_memory_arbitor_if.slave  vector_if,
  rv32v_memory_arbitor_if.master bus_if
);
  arb_state_t            state_q, state_d;
  logic                  scalar_req_s, vector_req_s, scalar_older_s;
  logic                  scalar_busy_s, vector_busy_s;
  logic                  bus_ren_q, bus_wen_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [BE_W-1:0]       bus_byte_en_q;
  logic [DATA_WIDTH-1:0] scalar_rdata_q, vector_rdata_q;

  assign scalar_req_s = scalar_if.ren | scalar_if.wen;
  assign vector_req_s = vector_if.ren | vector_if.wen;

  rv32v_cb_age_compare #(.CB_IDX_W(CB_IDX_W)) u_age_cmp (
    .tail_i        (cb_tail_index),
    .scalar_idx_i  (scalar_cb_index),
    .vector_idx_i  (vector_cb_index),
    .scalar_older_o(scalar_older_s)
  );

  rv32v_memory_arbitor_chk u_chk (
    .clk_i       (CLK),
    .rst_i       (RST),
    .scalar_ren_i(scalar_if.ren),
    .scalar_wen_i(scalar_if.wen),
    .vector_ren_i(vector_if.ren),
    .vector_wen_i(vector_if.wen)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: grant from IDLE by age, hold until the bus reports completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scalar_req_s && (!vector_req_s || scalar_older_s)) state_d = SCALAR_XFER;
        else if (vector_req_s)                                 state_d = VECTOR_XFER;
        else                                                   state_d = IDLE;
      end
      SCALAR_XFER, VECTOR_XFER: begin
        if (!bus_if.busy) state_d = IDLE;
        else              state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request registers load on grant; read data is captured on completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_ren_q      <= 1'b0;
      bus_wen_q      <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_byte_en_q  <= '0;
      scalar_rdata_q <= '0;
      vector_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_d == SCALAR_XFER) begin
            bus_ren_q     <= scalar_if.ren & ~scalar_if.wen;
            bus_wen_q     <= scalar_if.wen;
            bus_addr_q    <= scalar_if.addr;
            bus_wdata_q   <= scalar_if.wdata;
            bus_byte_en_q <= scalar_if.byte_en;
          end else if (state_d == VECTOR_XFER) begin
            bus_ren_q     <= vector_if.ren & ~vector_if.wen;
            bus_wen_q     <= vector_if.wen;
            bus_addr_q    <= vector_if.addr;
            bus_wdata_q   <= vector_if.wdata;
            bus_byte_en_q <= vector_if.byte_en;
          end else begin
            bus_ren_q <= 1'b0;
            bus_wen_q <= 1'b0;
          end
        end
        SCALAR_XFER: begin
          if (!bus_if.busy) begin
            bus_ren_q <= 1'b0;
            bus_wen_q <= 1'b0;
            if (bus_ren_q) scalar_rdata_q <= bus_if.rdata;
          end
        end
        VECTOR_XFER: begin
          if (!bus_if.busy) begin
            bus_ren_q <= 1'b0;
            bus_wen_q <= 1'b0;
            if (bus_ren_q) vector_rdata_q <= bus_if.rdata;
          end
        end
        default: begin
          bus_ren_q <= 1'b0;
          bus_wen_q <= 1'b0;
        end
      endcase
    end
  end

  // Requester busy: only the granted side sees the bus completion, same cycle.
  always_comb begin
    scalar_busy_s = 1'b1;
    vector_busy_s = 1'b1;
    case (state_q)
      SCALAR_XFER: scalar_busy_s = bus_if.busy;
      VECTOR_XFER: vector_busy_s = bus_if.busy;
      default: begin
        scalar_busy_s = 1'b1;
        vector_busy_s = 1'b1;
      end
    endcase
  end

  assign bus_if.ren       = bus_ren_q;
  assign bus_if.wen       = bus_wen_q;
  assign bus_if.addr      = bus_addr_q;
  assign bus_if.wdata     = bus_wdata_q;
  assign bus_if.byte_en   = bus_byte_en_q;
  assign scalar_if.rdata  = scalar_rdata_q;
  assign scalar_if.busy   = scalar_busy_s;
  assign vector_if.rdata  = vector_rdata_q;
  assign vector_if.busy   = vector_busy_s;
endmodule

// File: tb/tb_rv32v_memory_arbitor.sv
// Scoreboard bench for rv32v_memory_arbitor: directed plan items plus random rounds.
`timescale 1ns/1ps
module tb_rv32v_memory_arbitor;
  import rv32v_types_pkg::*;

  localparam int NCB = 16;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] tail, sidx, vidx;

  rv32v_memory_arbitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  rv32v_memory_arbitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) v_if ();
  rv32v_memory_arbitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_if ();

  rv32v_memory_arbitor #(.NUM_CB_ENTRY(NCB), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RST(rst),
    .cb_tail_index(tail), .scalar_cb_index(sidx), .vector_cb_index(vidx),
    .scalar_if(s_if), .vector_if(v_if), .bus_if(b_if)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          bus_lat = 1;
  logic        rd_force_en = 1'b0;
  logic [31:0] rd_force_val = 32'h0;
  logic [31:0] last_s_rd = 32'h0;
  logic [31:0] last_v_rd = 32'h0;

  mem_req_t    exp_bus_q[$];
  logic [31:0] exp_s_rd_q[$];
  logic [31:0] exp_v_rd_q[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Bench-defined bus memory contents.
  function automatic logic [31:0] bus_value(input logic [31:0] a);
    if (rd_force_en) return rd_force_val;
    else             return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic mem_req_t mk(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be);
    mem_req_t m;
    m.ren = r; m.wen = w; m.addr = a; m.wdata = d; m.byte_en = be;
    return m;
  endfunction

  function automatic mem_req_t rand_req(input logic side);
    int k;
    mem_req_t m;
    k = int'($urandom_range(0, 7));
    m = mk(k <= 4, (k == 0) || (k >= 5), {side, 31'($urandom)}, $urandom, 4'($urandom));
    return m;
  endfunction

  // Model of one completed transaction: bus request (write beats read) and rdata afterwards.
  task automatic push_exp(input logic is_s, input mem_req_t r);
    mem_req_t e;
    e = r;
    e.ren = r.ren & ~r.wen;
    exp_bus_q.push_back(e);
    if (is_s) begin
      if (e.ren) last_s_rd = bus_value(e.addr);
      exp_s_rd_q.push_back(last_s_rd);
    end else begin
      if (e.ren) last_v_rd = bus_value(e.addr);
      exp_v_rd_q.push_back(last_v_rd);
    end
  endtask

  // Bus responder: busy drops on the bus_lat-th cycle of an access.
  initial begin : responder
    int k;
    k = 0;
    b_if.busy  = 1'b1;
    b_if.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst || !(b_if.ren || b_if.wen)) begin
        k = 0;
        b_if.busy = 1'b1;
      end else begin
        k++;
        b_if.busy  = (k < bus_lat) ? 1'b1 : 1'b0;
        b_if.rdata = bus_value(b_if.addr);
      end
    end
  end

  // Bus monitor: each new access must match the next expected grant and stay stable.
  initial begin : bus_mon
    logic     prev;
    mem_req_t cur, snap, e;
    prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (b_if.ren || b_if.wen) begin
        cur = mk(b_if.ren, b_if.wen, b_if.addr, b_if.wdata, b_if.byte_en);
        if (!prev) begin
          if (exp_bus_q.size() == 0) fail_now("bus_unexpected_access");
          else begin
            e = exp_bus_q.pop_front();
            check("bus_request", cur, e);
          end
          snap = cur;
        end else begin
          check("bus_stable", cur, snap);
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  end

  // Completion monitor: one-cycle busy pulses, loser stays busy, rdata next cycle.
  initial begin : done_mon
    logic s_low_prev, v_low_prev, s_pend, v_pend;
    logic [31:0] s_exp, v_exp;
    s_low_prev = 1'b0; v_low_prev = 1'b0; s_pend = 1'b0; v_pend = 1'b0;
    s_exp = 32'h0; v_exp = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_low_prev = 1'b0; v_low_prev = 1'b0; s_pend = 1'b0; v_pend = 1'b0;
      end else begin
        if (s_pend) begin check("scalar_rdata", s_if.rdata, s_exp); s_pend = 1'b0; end
        if (v_pend) begin check("vector_rdata", v_if.rdata, v_exp); v_pend = 1'b0; end
        if (!s_if.busy) begin
          check("scalar_busy_one_cycle", s_low_prev, 1'b0);
          check("vector_busy_while_scalar_done", v_if.busy, 1'b1);
          if (exp_s_rd_q.size() == 0) fail_now("scalar_unexpected_done");
          else begin s_exp = exp_s_rd_q.pop_front(); s_pend = 1'b1; end
        end
        if (!v_if.busy) begin
          check("vector_busy_one_cycle", v_low_prev, 1'b0);
          check("scalar_busy_while_vector_done", s_if.busy, 1'b1);
          if (exp_v_rd_q.size() == 0) fail_now("vector_unexpected_done");
          else begin v_exp = exp_v_rd_q.pop_front(); v_pend = 1'b1; end
        end
        s_low_prev = !s_if.busy;
        v_low_prev = !v_if.busy;
      end
    end
  end

  // Requester: waits del cycles, holds the request until busy=0, then drops it.
  task automatic drive_side(input logic is_s, input logic on, input mem_req_t r, input int del);
    int  n;
    logic done;
    if (on) begin
      if (del > 0) begin
        repeat (del) @(posedge clk);
        #1;
      end
      if (is_s) begin
        s_if.ren = r.ren; s_if.wen = r.wen; s_if.addr = r.addr; s_if.wdata = r.wdata; s_if.byte_en = r.byte_en;
      end else begin
        v_if.ren = r.ren; v_if.wen = r.wen; v_if.addr = r.addr; v_if.wdata = r.wdata; v_if.byte_en = r.byte_en;
      end
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
        @(negedge clk);
        done = is_s ? !s_if.busy : !v_if.busy;
        n++;
      end
      if (!done) fail_now(is_s ? "scalar_done_timeout" : "vector_done_timeout");
      @(posedge clk); #1;
      if (is_s) begin s_if.ren = 1'b0; s_if.wen = 1'b0; end
      else      begin v_if.ren = 1'b0; v_if.wen = 1'b0; end
    end
  endtask

  // One arbitration round; expected grant order comes from arrival time, then CB age.
  task automatic run_round(input logic s_on, input mem_req_t sr, input int sdel,
                           input logic v_on, input mem_req_t vr, input int vdel,
                           input logic [IW-1:0] t, input logic [IW-1:0] si,
                           input logic [IW-1:0] vi, input int lat);
    int   age_s, age_v;
    logic s_first;
    tail = t; sidx = si; vidx = vi; bus_lat = lat;
    age_s = (int'(si) - int'(t) + NCB) % NCB;
    age_v = (int'(vi) - int'(t) + NCB) % NCB;
    if (s_on && v_on) s_first = (sdel < vdel) ? 1'b1 : (vdel < sdel) ? 1'b0 : (age_s <= age_v);
    else              s_first = s_on;
    if (s_first) begin
      push_exp(1'b1, sr);
      if (v_on) push_exp(1'b0, vr);
    end else begin
      push_exp(1'b0, vr);
      if (s_on) push_exp(1'b1, sr);
    end
    fork
      drive_side(1'b1, s_on, sr, sdel);
      drive_side(1'b0, v_on, vr, vdel);
    join
    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_drained", exp_bus_q.size(), 0);
    check("done_queues_drained", exp_s_rd_q.size() + exp_v_rd_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic     s_on, v_on;
    mem_req_t sr, vr;
    rst = 1'b1;
    tail = '0; sidx = '0; vidx = '0;
    s_if.ren = 1'b0; s_if.wen = 1'b0; s_if.addr = 32'h0; s_if.wdata = 32'h0; s_if.byte_en = 4'h0;
    v_if.ren = 1'b0; v_if.wen = 1'b0; v_if.addr = 32'h0; v_if.wdata = 32'h0; v_if.byte_en = 4'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bus_ren", b_if.ren, 1'b0);
    check("rst_bus_wen", b_if.wen, 1'b0);
    check("rst_bus_addr", b_if.addr, 32'h0);
    check("rst_bus_wdata", b_if.wdata, 32'h0);
    check("rst_bus_be", b_if.byte_en, 4'h0);
    check("rst_busy", {s_if.busy, v_if.busy}, 2'b11);
    check("rst_rdata", {s_if.rdata, v_if.rdata}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Scalar-only read, completes on the second bus cycle
    rd_force_en = 1'b1; rd_force_val = 32'hDEAD_BEEF;
    fork
      run_round(1'b1, mk(1'b1, 1'b0, 32'h100, 32'h0, 4'hF), 0, 1'b0, '0, 0, 4'd0, 4'd0, 4'd0, 2);
      begin
        repeat (2) @(negedge clk);
        check("latency_bus_addr", b_if.addr, 32'h100);
        check("latency_bus_ren", b_if.ren, 1'b1);
      end
    join
    rd_force_en = 1'b0;

    // Contention without and with index wrap
    run_round(1'b1, mk(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF), 0,
              1'b1, mk(1'b1, 1'b0, 32'h8000_0300, 32'h0, 4'hF), 0, 4'd3, 4'd7, 4'd5, 1);
    run_round(1'b1, mk(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h3), 0,
              1'b1, mk(1'b1, 1'b0, 32'h8000_0500, 32'h0, 4'hC), 0, 4'd14, 4'd1, 4'd0, 2);
    run_round(1'b1, mk(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF), 0,
              1'b1, mk(1'b1, 1'b0, 32'h8000_0700, 32'h0, 4'hF), 0, 4'd14, 4'd15, 4'd2, 1);

    // No preemption: older scalar arrives while a long vector write is in flight
    run_round(1'b1, mk(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF), 2,
              1'b1, mk(1'b0, 1'b1, 32'h8000_0900, 32'hCAFE_F00D, 4'h5), 0, 4'd0, 4'd1, 4'd8, 5);

    // Equal age goes to scalar; read+write on one side becomes a write
    run_round(1'b1, mk(1'b1, 1'b1, 32'h0000_0A00, 32'h1234_5678, 4'hF), 0,
              1'b1, mk(1'b1, 1'b0, 32'h8000_0B00, 32'h0, 4'hF), 0, 4'd4, 4'd9, 4'd9, 1);

    // Reset in the middle of a vector transfer with the bus still busy
    bus_lat = 50;
    v_if.ren = 1'b0; v_if.wen = 1'b1; v_if.addr = 32'h8000_0C00; v_if.wdata = 32'h5555_AAAA; v_if.byte_en = 4'hF;
    exp_bus_q.push_back(mk(1'b0, 1'b1, 32'h8000_0C00, 32'h5555_AAAA, 4'hF));
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_vector_xfer", b_if.wen, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_bus_ren_wen", {b_if.ren, b_if.wen}, 2'b00);
    check("midrst_bus_addr", b_if.addr, 32'h0);
    check("midrst_busy", {s_if.busy, v_if.busy}, 2'b11);
    check("midrst_rdata", {s_if.rdata, v_if.rdata}, 64'h0);
    last_s_rd = 32'h0; last_v_rd = 32'h0;
    @(posedge clk); #1;
    v_if.wen = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {b_if.ren, b_if.wen}, 2'b00);

    // Random rounds against the arrival/age model
    for (int r = 0; r < 40; r++) begin
      s_on = ($urandom_range(0, 3) != 0);
      v_on = ($urandom_range(0, 3) != 0);
      if (!s_on && !v_on) v_on = 1'b1;
      sr = rand_req(1'b0);
      vr = rand_req(1'b1);
      run_round(s_on, sr, int'($urandom_range(0, 2)), v_on, vr, int'($urandom_range(0, 2)),
                4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(1, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32v_memory_arbitor.md
Name: rv32v_memory_arbitor

Overview:
Single-port memory arbiter between the scalar pipeline and the vector lane memory stage. It is the consumer end of the completion-buffer index interface, taking the CB tail, scalar CB index and vector CB index.
- When both sides request, the one whose instruction is oldest relative to the CB tail is granted.
- The grant is held for the whole bus transaction.
- The arbiter sits between the two memory stages and the shared generic data bus toward the dcache.

Parameters:
NUM_CB_ENTRY, 16, completion buffer depth (power of 2); CB_IDX_W = $clog2(NUM_CB_ENTRY)
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width; byte enable width BE_W = DATA_WIDTH/8

Ports:
CLK  input  1  clock
RST  input  1  asynchronous, active-high reset
cb_tail_index  input  CB_IDX_W  oldest in-flight CB entry (commit pointer)
scalar_cb_index  input  CB_IDX_W  CB entry of the scalar memory op
vector_cb_index  input  CB_IDX_W  CB entry of the vector memory op
scalar_ren / scalar_wen  input  1  scalar read / write request
scalar_addr  input  ADDR_WIDTH  scalar address
scalar_wdata  input  DATA_WIDTH  scalar write data
scalar_byte_en  input  BE_W  scalar byte enables
scalar_rdata  output  DATA_WIDTH  scalar read data
scalar_busy  output  1  low for exactly one cycle when the scalar transaction completes
vector_ren / vector_wen / vector_addr / vector_wdata / vector_byte_en  input  (as scalar)  vector request
vector_rdata  output  DATA_WIDTH  vector read data
vector_busy  output  1  as scalar_busy
bus_ren / bus_wen  output  1  bus request
bus_addr  output  ADDR_WIDTH  bus address
bus_wdata  output  DATA_WIDTH  bus write data
bus_byte_en  output  BE_W  bus byte enables
bus_rdata  input  DATA_WIDTH  bus read data
bus_busy  input  1  low when the bus completes the current access

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - bus_ren=bus_wen=0; bus_addr, bus_wdata, bus_byte_en = 0.
  - scalar_busy=vector_busy=1; scalar_rdata=vector_rdata=0.
- Age is (idx - cb_tail_index) mod NUM_CB_ENTRY, computed in CB_IDX_W bits with natural wrap. The smaller age is older.
- Request present means ren|wen. If ren and wen are both asserted on one side, wen wins and a simulation assertion fires.
- FSM states: IDLE, SCALAR_XFER, VECTOR_XFER.
- IDLE:
  - Only scalar requests: grant scalar.
  - Only vector requests: grant vector.
  - Both request: grant the smaller age; equal age grants scalar.
  - On grant, register the winner's addr/wdata/byte_en/ren/wen into the bus_* outputs next cycle and go to <WINNER>_XFER.
  - No request: stay in IDLE with bus_ren=bus_wen=0.
- *_XFER:
  - bus_* outputs stay registered and stable; requester inputs are not re-sampled.
  - When bus_busy=0: capture bus_rdata into the winner's *_rdata (reads only; writes leave rdata unchanged). Drive the winner's *_busy=0 for that same cycle, combinational from bus_busy. Clear bus_ren/bus_wen next edge and return to IDLE.
  - The loser's busy stays 1 throughout.
- Latency: request seen in cycle N, bus request in N+1, earliest done (busy=0) in N+1 if bus_busy is already low. Back-to-back grants need one IDLE cycle between them.
- Requesters hold their request until they see busy=0. Deasserting a request during its own XFER does not abort it: the bus access completes and busy=0 is still pulsed.
- An arriving older request never preempts an in-flight transaction.
- Reset mid-XFER drops the transaction: outputs return to reset values immediately.

Decomposition:
- Package rv32v_types_pkg holds:
  - the arb_state_t enum {IDLE, SCALAR_XFER, VECTOR_XFER};
  - a mem_req_t struct {ren, wen, addr, wdata, byte_en};
  - a cb_age function taking (idx, tail).
- Sub-module rv32v_cb_age_compare: combinational; inputs are tail and two indices; output is scalar_older (tie-inclusive). Shared with the future CB commit logic.

Test Plan:
- Reset: RST pulsed mid-VECTOR_XFER with bus_busy=1 -> state IDLE, bus_ren=bus_wen=0, both busy=1, same cycle.
- Scalar-only read: scalar_ren=1, addr=0x100, bus_busy low on 2nd bus cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100 one cycle after request; scalar_rdata=0xDEADBEEF; scalar_busy=0 for exactly 1 cycle; vector_busy=1 throughout.
- Contention, no wrap: tail=3, scalar_idx=7 (age 4), vector_idx=5 (age 2), both read -> vector granted first; scalar granted after the vector's done cycle plus one IDLE cycle.
- Contention, wrap: tail=14, scalar_idx=1 (age 3), vector_idx=0 (age 2) -> vector granted. Then tail=14, scalar_idx=15 (age 1), vector_idx=2 (age 4) -> scalar granted.
- No preemption: vector write in XFER with bus_busy held high 5 cycles; scalar with older index requests in cycle 2 -> bus_addr/bus_wdata unchanged until vector done; scalar granted afterwards. Vector write leaves vector_rdata unchanged.
- Tie and illegal: scalar_idx=vector_idx=9 -> scalar wins. scalar_ren=scalar_wen=1 -> bus_wen=1, bus_ren=0, assertion reported.
